// File: rtl/pong_arena.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pong_arena                                                        |
// | Brief  : Two-player pong game state (ball, paddles, scores) with a         |
// |          registered per-pixel video bit for a raster scan.                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module pong_arena #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int PADDLE_H      = 40,
    parameter int PADDLE_W      = 4,
    parameter int PADDLE_MARGIN = 8,
    parameter int BALL_SIZE     = 4,
    parameter int BALL_SPEED    = 2,
    parameter int PADDLE_SPEED  = 3,
    parameter int WIN_SCORE     = 9,
    parameter int SERVE_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] btn_up,
    input  logic [1:0] btn_down,
    input  logic       ai_en,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       pixel,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       game_over,
    output logic       winner
);

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]  c_SW        = 10'(SCREEN_W);
    localparam logic [9:0]  c_SH        = 10'(SCREEN_H);
    localparam logic [9:0]  c_BX0       = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0]  c_BY0       = 9'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [8:0]  c_PAD0      = 9'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [8:0]  c_PMAX      = 9'(SCREEN_H - PADDLE_H);
    localparam logic [8:0]  c_PS        = 9'(PADDLE_SPEED);
    localparam logic [9:0]  c_PS10      = 10'(PADDLE_SPEED);
    localparam logic [9:0]  c_PH        = 10'(PADDLE_H);
    localparam logic [9:0]  c_PH_HALF   = 10'(PADDLE_H / 2);
    localparam logic [9:0]  c_BS        = 10'(BALL_SIZE);
    localparam logic [9:0]  c_BS_HALF   = 10'(BALL_SIZE / 2);
    localparam logic [8:0]  c_YMAX      = 9'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  c_XMAX      = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]  c_LHIT      = 10'(PADDLE_MARGIN + PADDLE_W);
    localparam logic [9:0]  c_RHIT      = 10'(SCREEN_W - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);
    localparam logic [9:0]  c_P0X       = 10'(PADDLE_MARGIN);
    localparam logic [9:0]  c_P0X_END   = 10'(PADDLE_MARGIN + PADDLE_W);
    localparam logic [9:0]  c_P1X       = 10'(SCREEN_W - PADDLE_MARGIN - PADDLE_W);
    localparam logic [9:0]  c_P1X_END   = 10'(SCREEN_W - PADDLE_MARGIN);
    localparam logic [9:0]  c_NET0      = 10'(SCREEN_W / 2 - 1);
    localparam logic [9:0]  c_NET1      = 10'(SCREEN_W / 2);
    localparam logic [3:0]  c_WIN       = 4'(WIN_SCORE);
    localparam logic [CW-1:0] c_SERVE_LAST = CW'(SERVE_FRAMES - 1);

    localparam logic signed [10:0] c_BSX    = 11'(BALL_SPEED);
    localparam logic signed [9:0]  c_BSY    = 10'(BALL_SPEED);
    localparam logic signed [10:0] c_LHIT_S = 11'(PADDLE_MARGIN + PADDLE_W);
    localparam logic signed [10:0] c_RHIT_S = 11'(SCREEN_W - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);
    localparam logic signed [10:0] c_XMAX_S = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [9:0]  c_YMAX_S = 10'(SCREEN_H - BALL_SIZE);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t        r_state,  w_state_nx;
    logic [CW-1:0] r_cnt,    w_cnt_nx;
    logic [9:0]    r_ball_x, w_ball_x_nx;
    logic [8:0]    r_ball_y, w_ball_y_nx;
    logic          r_dx,     w_dx_nx;      // 1 = moving right
    logic          r_dy,     w_dy_nx;      // 1 = moving down
    logic [8:0]    r_pad0_y, w_pad0_nx;
    logic [8:0]    r_pad1_y, w_pad1_nx;
    logic [3:0]    r_score0, w_score0_nx;
    logic [3:0]    r_score1, w_score1_nx;
    logic          r_game_over, w_go_nx;
    logic          r_winner, w_winner_nx;
    logic          r_scorer, w_scorer_nx;
    logic          r_pixel;

    logic signed [10:0] w_nx;
    logic signed [9:0]  w_ny;
    logic [9:0]  w_pc, w_bc;
    logic        w_ai_up, w_ai_dn, w_up1, w_dn1;
    logic [8:0]  w_pad0_mv, w_pad1_mv;
    logic        w_ovl0, w_ovl1, w_hit0, w_hit1;
    logic [3:0]  w_inc;
    logic        w_pix;

    function automatic logic [8:0] f_pad(input logic [8:0] py, input logic up, input logic dn);
        if (up && !dn)
            return (py < c_PS) ? 9'd0 : py - c_PS;
        if (dn && !up)
            return (py > c_PMAX - c_PS) ? c_PMAX : py + c_PS;
        return py;
    endfunction

    assign w_nx = r_dx ? $signed({1'b0, r_ball_x}) + c_BSX : $signed({1'b0, r_ball_x}) - c_BSX;
    assign w_ny = r_dy ? $signed({1'b0, r_ball_y}) + c_BSY : $signed({1'b0, r_ball_y}) - c_BSY;

    // The computer player chases the ball centre with a dead band of one step
    assign w_pc    = {1'b0, r_pad1_y} + c_PH_HALF;
    assign w_bc    = {1'b0, r_ball_y} + c_BS_HALF;
    assign w_ai_up = w_pc > w_bc + c_PS10;
    assign w_ai_dn = w_bc > w_pc + c_PS10;
    assign w_up1   = ai_en ? w_ai_up : btn_up[1];
    assign w_dn1   = ai_en ? w_ai_dn : btn_down[1];

    assign w_pad0_mv = f_pad(r_pad0_y, btn_up[0], btn_down[0]);
    assign w_pad1_mv = f_pad(r_pad1_y, w_up1, w_dn1);

    assign w_ovl0 = ({1'b0, r_ball_y} + c_BS > {1'b0, r_pad0_y}) &&
                    ({1'b0, r_ball_y} < {1'b0, r_pad0_y} + c_PH);
    assign w_ovl1 = ({1'b0, r_ball_y} + c_BS > {1'b0, r_pad1_y}) &&
                    ({1'b0, r_ball_y} < {1'b0, r_pad1_y} + c_PH);
    assign w_hit0 = !r_dx && (w_nx <= c_LHIT_S) && w_ovl0;
    assign w_hit1 =  r_dx && (w_nx >= c_RHIT_S) && w_ovl1;

    assign w_inc = (r_scorer ? r_score1 : r_score0) + 4'd1;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_ball_x_nx = r_ball_x;
        w_ball_y_nx = r_ball_y;
        w_dx_nx     = r_dx;
        w_dy_nx     = r_dy;
        w_pad0_nx   = r_pad0_y;
        w_pad1_nx   = r_pad1_y;
        w_score0_nx = r_score0;
        w_score1_nx = r_score1;
        w_go_nx     = r_game_over;
        w_winner_nx = r_winner;
        w_scorer_nx = r_scorer;
        case (r_state)
            ST_SERVE: begin
                w_pad0_nx   = w_pad0_mv;
                w_pad1_nx   = w_pad1_mv;
                w_ball_x_nx = c_BX0;
                w_ball_y_nx = c_BY0;
                if (r_cnt == c_SERVE_LAST) begin
                    w_state_nx = ST_PLAY;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            ST_PLAY: begin
                w_pad0_nx = w_pad0_mv;
                w_pad1_nx = w_pad1_mv;
                if (w_ny < 10'sd0) begin
                    w_ball_y_nx = '0;
                    w_dy_nx     = 1'b1;
                end else if (w_ny > c_YMAX_S) begin
                    w_ball_y_nx = c_YMAX;
                    w_dy_nx     = 1'b0;
                end else begin
                    w_ball_y_nx = w_ny[8:0];
                end
                if (w_hit0) begin
                    w_ball_x_nx = c_LHIT;
                    w_dx_nx     = 1'b1;
                end else if (w_hit1) begin
                    w_ball_x_nx = c_RHIT;
                    w_dx_nx     = 1'b0;
                end else if (!r_dx && (w_nx <= 11'sd0)) begin
                    w_ball_x_nx = '0;
                    w_scorer_nx = 1'b1;
                    w_state_nx  = ST_POINT;
                end else if (r_dx && (w_nx >= c_XMAX_S)) begin
                    w_ball_x_nx = c_XMAX;
                    w_scorer_nx = 1'b0;
                    w_state_nx  = ST_POINT;
                end else begin
                    w_ball_x_nx = w_nx[9:0];
                end
            end
            ST_POINT: begin
                if (r_scorer) w_score1_nx = w_inc;
                else          w_score0_nx = w_inc;
                if (w_inc == c_WIN) begin
                    w_state_nx  = ST_OVER;
                    w_go_nx     = 1'b1;
                    w_winner_nx = r_scorer;
                end else begin
                    // Serve toward the player who just scored
                    w_state_nx  = ST_SERVE;
                    w_cnt_nx    = '0;
                    w_ball_x_nx = c_BX0;
                    w_ball_y_nx = c_BY0;
                    w_dx_nx     = r_scorer;
                end
            end
            default: begin
                if ((|btn_up) || (|btn_down)) begin
                    w_state_nx  = ST_SERVE;
                    w_cnt_nx    = '0;
                    w_score0_nx = '0;
                    w_score1_nx = '0;
                    w_go_nx     = 1'b0;
                    w_ball_x_nx = c_BX0;
                    w_ball_y_nx = c_BY0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SERVE;
            r_cnt       <= '0;
            r_ball_x    <= c_BX0;
            r_ball_y    <= c_BY0;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_pad0_y    <= c_PAD0;
            r_pad1_y    <= c_PAD0;
            r_score0    <= '0;
            r_score1    <= '0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_scorer    <= 1'b0;
        end else if (frame_tick) begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_ball_x    <= w_ball_x_nx;
            r_ball_y    <= w_ball_y_nx;
            r_dx        <= w_dx_nx;
            r_dy        <= w_dy_nx;
            r_pad0_y    <= w_pad0_nx;
            r_pad1_y    <= w_pad1_nx;
            r_score0    <= w_score0_nx;
            r_score1    <= w_score1_nx;
            r_game_over <= w_go_nx;
            r_winner    <= w_winner_nx;
            r_scorer    <= w_scorer_nx;
        end
    end

    always_comb begin
        w_pix = 1'b0;
        if (x < c_SW && {1'b0, y} < c_SH) begin
            if (x >= c_P0X && x < c_P0X_END &&
                {1'b0, y} >= {1'b0, r_pad0_y} && {1'b0, y} < {1'b0, r_pad0_y} + c_PH)
                w_pix = 1'b1;
            if (x >= c_P1X && x < c_P1X_END &&
                {1'b0, y} >= {1'b0, r_pad1_y} && {1'b0, y} < {1'b0, r_pad1_y} + c_PH)
                w_pix = 1'b1;
            if (r_state != ST_OVER && x >= r_ball_x && x < r_ball_x + c_BS &&
                {1'b0, y} >= {1'b0, r_ball_y} && {1'b0, y} < {1'b0, r_ball_y} + c_BS)
                w_pix = 1'b1;
            if ((x == c_NET0 || x == c_NET1) && !y[3])
                w_pix = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pixel <= 1'b0;
        else     r_pixel <= w_pix;
    end

    assign pixel     = r_pixel;
    assign score0    = r_score0;
    assign score1    = r_score1;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_arena.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pong_arena                                                     |
// | Brief  : Self-checking bench for pong_arena against a behavioural model.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_pong_arena;

    localparam int SW = 640, SH = 480, PH = 40, PW = 4, PM = 8;
    localparam int BS = 4, BSP = 2, PSP = 3, WIN = 9, SF = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] btn_up = 2'b00;
    logic [1:0] btn_down = 2'b00;
    logic       ai_en = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       pixel, game_over, winner;
    logic [3:0] score0, score1;

    int total = 0;
    int bad = 0;

    pong_arena #(
        .SCREEN_W(SW), .SCREEN_H(SH), .PADDLE_H(PH), .PADDLE_W(PW),
        .PADDLE_MARGIN(PM), .BALL_SIZE(BS), .BALL_SPEED(BSP),
        .PADDLE_SPEED(PSP), .WIN_SCORE(WIN), .SERVE_FRAMES(SF)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .ai_en(ai_en),
        .x(x), .y(y), .pixel(pixel),
        .score0(score0), .score1(score1),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Game model: phase 0 serve, 1 play, 2 point, 3 over
    int m_phase, m_served, m_bx, m_by, m_dx, m_dy, m_p0, m_p1;
    int m_s0, m_s1, m_go, m_win, m_scorer, m_pix;
    bit m_valid = 1'b0;

    function automatic int step_pad(int p, bit up, bit dn);
        if (up && !dn) return (p - PSP < 0) ? 0 : p - PSP;
        if (dn && !up) return (p + PSP > SH - PH) ? SH - PH : p + PSP;
        return p;
    endfunction

    function automatic bit inside_rect(int px, int py, int rx, int ry, int w, int h);
        return px >= rx && px < rx + w && py >= ry && py < ry + h;
    endfunction

    function automatic int model_pixel(int px, int py);
        if (px >= SW || py >= SH) return 0;
        if (inside_rect(px, py, PM, m_p0, PW, PH)) return 1;
        if (inside_rect(px, py, SW - PM - PW, m_p1, PW, PH)) return 1;
        if (m_phase != 3 && inside_rect(px, py, m_bx, m_by, BS, BS)) return 1;
        if ((px == SW / 2 - 1 || px == SW / 2) && ((py / 8) % 2 == 0)) return 1;
        return 0;
    endfunction

    task automatic centre_ball();
        m_bx = (SW - BS) / 2;
        m_by = (SH - BS) / 2;
    endtask

    task automatic model_reset();
        m_phase = 0; m_served = 0; m_dx = 1; m_dy = 1;
        centre_ball();
        m_p0 = (SH - PH) / 2; m_p1 = (SH - PH) / 2;
        m_s0 = 0; m_s1 = 0; m_go = 0; m_win = 0; m_scorer = 0; m_pix = 0;
    endtask

    task automatic model_tick();
        int np0, np1, nx, ny, ndx, ndy, gap;
        bit hit_l, hit_r;
        np0 = m_p0; np1 = m_p1;
        if (m_phase <= 1) begin
            np0 = step_pad(m_p0, btn_up[0], btn_down[0]);
            if (ai_en) begin
                gap = (m_p1 + PH / 2) - (m_by + BS / 2);
                np1 = step_pad(m_p1, gap > PSP, gap < -PSP);
            end else begin
                np1 = step_pad(m_p1, btn_up[1], btn_down[1]);
            end
        end
        case (m_phase)
            0: begin
                centre_ball();
                m_served++;
                if (m_served == SF) begin m_phase = 1; m_served = 0; end
            end
            1: begin
                nx = m_bx + (m_dx ? BSP : -BSP);
                ny = m_by + (m_dy ? BSP : -BSP);
                ndx = m_dx; ndy = m_dy;
                if (ny < 0) begin ny = 0; ndy = 1; end
                else if (ny > SH - BS) begin ny = SH - BS; ndy = 0; end
                hit_l = !m_dx && nx <= PM + PW && m_by + BS > m_p0 && m_by < m_p0 + PH;
                hit_r = m_dx && nx >= SW - PM - PW - BS && m_by + BS > m_p1 && m_by < m_p1 + PH;
                if (hit_l) begin nx = PM + PW; ndx = 1; end
                else if (hit_r) begin nx = SW - PM - PW - BS; ndx = 0; end
                else if (!m_dx && nx <= 0) begin nx = 0; m_scorer = 1; m_phase = 2; end
                else if (m_dx && nx >= SW - BS) begin nx = SW - BS; m_scorer = 0; m_phase = 2; end
                m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
            end
            2: begin
                if (m_scorer == 1) m_s1++; else m_s0++;
                if ((m_scorer == 1 ? m_s1 : m_s0) == WIN) begin
                    m_phase = 3; m_go = 1; m_win = m_scorer;
                end else begin
                    m_phase = 0; m_served = 0; m_dx = m_scorer;
                    centre_ball();
                end
            end
            default: begin
                if (btn_up != 2'b00 || btn_down != 2'b00) begin
                    m_phase = 0; m_served = 0; m_s0 = 0; m_s1 = 0; m_go = 0;
                    centre_ball();
                end
            end
        endcase
        m_p0 = np0; m_p1 = np1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_pix = model_pixel(int'(x), int'(y));
            if (frame_tick) model_tick();
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pixel", int'(pixel), m_pix);
            chk("score0", int'(score0), m_s0);
            chk("score1", int'(score1), m_s1);
            chk("game_over", int'(game_over), m_go);
            if (m_go != 0) chk("winner", int'(winner), m_win);
            chk("state", int'(dut.r_state), m_phase);
            chk("ball_x", int'(dut.r_ball_x), m_bx);
            chk("ball_y", int'(dut.r_ball_y), m_by);
            chk("dx", int'(dut.r_dx), m_dx);
            chk("dy", int'(dut.r_dy), m_dy);
            chk("pad0_y", int'(dut.r_pad0_y), m_p0);
            chk("pad1_y", int'(dut.r_pad1_y), m_p1);
        end
    end

    bit scan_rand = 1'b1;
    bit tracker = 1'b0;

    task automatic cyc(bit t);
        if (scan_rand) begin
            x = 10'($urandom_range(0, 700));
            y = 9'($urandom_range(0, 511));
        end
        frame_tick = t;
        @(posedge clk); #1;
    endtask

    // Left player follows the ball; right player parks at the top
    task automatic do_tick();
        if (tracker) begin
            btn_up[0]   = (m_p0 + PH / 2) > (m_by + BS / 2 + PSP);
            btn_down[0] = (m_by + BS / 2) > (m_p0 + PH / 2 + PSP);
            btn_up[1]   = 1'b1;
            btn_down[1] = 1'b0;
        end
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
    endtask

    initial begin : main
        int guard;
        int saved;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ball_x", int'(dut.r_ball_x), 318);
        chk("rst_ball_y", int'(dut.r_ball_y), 238);
        chk("rst_pad1", int'(dut.r_pad1_y), 220);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_score0", int'(score0), 0);
        rst = 1'b0;

        repeat (59) do_tick();
        chk("serve_at_tick59", int'(dut.r_state), 0);
        do_tick();
        chk("play_at_tick60", int'(dut.r_state), 1);
        chk("ball_x_tick60", int'(dut.r_ball_x), 318);
        do_tick();
        chk("ball_x_tick61", int'(dut.r_ball_x), 320);
        chk("ball_y_tick61", int'(dut.r_ball_y), 240);
        repeat (118) do_tick();
        chk("wall_y_reach", int'(dut.r_ball_y), 476);
        chk("wall_dy_before", int'(dut.r_dy), 1);
        do_tick();
        chk("wall_y_clamp", int'(dut.r_ball_y), 476);
        chk("wall_dy_flip", int'(dut.r_dy), 0);
        do_tick();
        chk("wall_y_back", int'(dut.r_ball_y), 474);

        // Reset landing on a tick cycle mid-play
        rst = 1'b1;
        cyc(1'b1);
        chk("midplay_rst_state", int'(dut.r_state), 0);
        chk("midplay_rst_ball_y", int'(dut.r_ball_y), 238);
        chk("midplay_rst_pixel", int'(pixel), 0);
        rst = 1'b0;

        btn_up = 2'b01; btn_down = 2'b01;
        repeat (3) do_tick();
        chk("pad_both_hold", int'(dut.r_pad0_y), 220);
        btn_down = 2'b00;
        repeat (73) do_tick();
        chk("pad_up_73", int'(dut.r_pad0_y), 1);
        do_tick();
        chk("pad_up_74", int'(dut.r_pad0_y), 0);
        repeat (26) do_tick();
        chk("pad_up_sat", int'(dut.r_pad0_y), 0);
        btn_up = 2'b00;

        // Pixel scan on a non-tick cycle
        scan_rand = 1'b0;
        x = 10'(m_bx); y = 9'(m_by);
        cyc(1'b0);
        chk("pixel_on_ball", int'(pixel), 1);
        x = 10'd640; y = 9'd0;
        cyc(1'b0);
        chk("pixel_offscreen", int'(pixel), 0);
        x = 10'd319; y = 9'd2;
        cyc(1'b0);
        chk("pixel_net", int'(pixel), 1);
        scan_rand = 1'b1;

        // Computer right player, idle left player
        apply_reset();
        ai_en = 1'b1;
        guard = 0;
        while (score1 != 4'd1 && guard < 3000) begin do_tick(); guard++; end
        chk("left_miss_score1", int'(score1), 1);
        chk("after_point_serve", int'(dut.r_state), 0);
        chk("after_point_dx_right", int'(dut.r_dx), 1);
        repeat (1500) do_tick();
        chk("ai_never_misses", int'(score0), 0);

        // Left tracker wins a full game; ai released mid-game
        apply_reset();
        repeat (100) do_tick();
        ai_en = 1'b0;
        tracker = 1'b1;
        guard = 0;
        while (!game_over && guard < 12000) begin do_tick(); guard++; end
        tracker = 1'b0;
        btn_up = 2'b00; btn_down = 2'b00;
        chk("win_game_over", int'(game_over), 1);
        chk("win_score0", int'(score0), 9);
        chk("win_score1", int'(score1), 0);
        chk("win_winner_left", int'(winner), 0);
        chk("win_state_over", int'(dut.r_state), 3);

        saved = m_p1;
        ai_en = 1'b1;
        repeat (3) do_tick();
        chk("over_pad1_frozen", int'(dut.r_pad1_y), saved);
        scan_rand = 1'b0;
        x = 10'(m_bx); y = 9'(m_by);
        cyc(1'b0);
        chk("over_ball_hidden", int'(pixel), 0);
        scan_rand = 1'b1;
        ai_en = 1'b0;

        btn_down = 2'b10;
        do_tick();
        btn_down = 2'b00;
        chk("restart_score0", int'(score0), 0);
        chk("restart_game_over", int'(game_over), 0);
        chk("restart_state", int'(dut.r_state), 0);
        repeat (5) do_tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_arena.md
PONG_ARENA -- requirements
Module: pong_arena

Interface
REQ-001 Parameter SCREEN_W, 640, visible width in pixels.
REQ-002 Parameter SCREEN_H, 480, visible height in pixels.
REQ-003 Parameter PADDLE_H, 40, paddle height; PADDLE_W, 4, paddle width; PADDLE_MARGIN, 8, paddle-to-screen-edge gap in x.
REQ-004 Parameter BALL_SIZE, 4, square ball edge; BALL_SPEED, 2, ball step per frame per axis; PADDLE_SPEED, 3, paddle step per frame.
REQ-005 Parameter WIN_SCORE, 9, winning score (max 15); SERVE_FRAMES, 60, frames held in SERVE.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 frame_tick  in  1  one-cycle pulse per frame; all game state advances only on cycles where it is 1.
REQ-009 btn_up, btn_down  in  2 each  clean (already debounced) levels; bit 0 = left player, bit 1 = right player.
REQ-010 ai_en  in  1  1 = right paddle computer-controlled, its buttons ignored.
REQ-011 x  in  10, y  in  9  current pixel coordinates.
REQ-012 pixel  out  1  registered video bit.
REQ-013 score0, score1  out  4 each  left/right scores; game_over  out  1; winner  out  1 (0 left, 1 right, valid while game_over).

Function
REQ-014 State machine SHALL have states SERVE, PLAY, POINT, OVER; transitions only on frame_tick.
REQ-015 SERVE: ball held at ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2); serve counter counts frames; after SERVE_FRAMES ticks -> PLAY.
REQ-016 PLAY: each tick ball_x += ±BALL_SPEED, ball_y += ±BALL_SPEED per dx/dy direction bits; next-position math one bit wider than position, signed.
REQ-017 Wall: next y < 0 -> y=0, dy flips to down; next y > SCREEN_H-BALL_SIZE -> y clamped to that, dy flips to up.
REQ-018 Left paddle hit: moving left, next x <= PADDLE_MARGIN+PADDLE_W, and ball_y+BALL_SIZE > pad0_y and ball_y < pad0_y+PADDLE_H -> x=PADDLE_MARGIN+PADDLE_W, dx flips; right paddle symmetric at SCREEN_W-PADDLE_MARGIN-PADDLE_W-BALL_SIZE.
REQ-019 Miss: moving left and next x <= 0 without hit -> right scores, go POINT; moving right and next x >= SCREEN_W-BALL_SIZE without hit -> left scores, go POINT.
REQ-020 Simultaneous wall and paddle events in one tick SHALL both apply (both directions flip).
REQ-021 POINT (one tick): scorer's score +1; if it equals WIN_SCORE -> OVER, game_over=1, winner set; else -> SERVE with dx toward the player who scored, dy unchanged.
REQ-022 Paddles move in SERVE and PLAY: up only -> y -= PADDLE_SPEED saturating at 0; down only -> y += PADDLE_SPEED saturating at SCREEN_H-PADDLE_H; both or neither -> hold.
REQ-023 ai_en=1: right paddle moves PADDLE_SPEED toward ball centre when |paddle centre - ball centre| > PADDLE_SPEED, else holds; same saturation.
REQ-024 OVER: ball hidden, paddles frozen; any btn_up or btn_down bit high on a tick -> scores cleared, game_over=0, SERVE.
REQ-025 pixel SHALL be registered, latency 1 cycle from x,y: 1 inside either paddle rectangle, inside ball (not in OVER), or net (x in {SCREEN_W/2-1, SCREEN_W/2} and y[3]=0); 0 when x>=SCREEN_W or y>=SCREEN_H.
REQ-026 ai_en change mid-game SHALL take effect on the next tick with no state disturbance.

Reset
REQ-027 rst=1 at any time, including mid-PLAY or mid-tick: state SERVE, serve counter 0, ball centred, dx right, dy down, both paddles at (SCREEN_H-PADDLE_H)/2, scores 0, game_over 0, winner 0, pixel 0, next cycle.

Verification
REQ-028 Reset, hold buttons low, 60 ticks -> state PLAY on tick 60; ball x 318 at tick 60, 320 at tick 61.
REQ-029 Left btn_up held 100 ticks from y=220 -> paddle y 220,217,...,1,0 then stays 0; up+down together -> y unchanged.
REQ-030 Ball moving up at y=1 -> next tick y=0, dy down; at y=475 moving down -> y=476, dy up.
REQ-031 Left paddle away from ball path, ball reaches x<=0 -> score1=1, SERVE, dx right after POINT.
REQ-032 Force score0=8, left scores -> score0=9, game_over=1, winner=0; any button on tick -> scores 0, SERVE.
REQ-033 Scan x=ball_x,y=ball_y -> pixel=1 one cycle later; x=640 -> pixel=0; ai_en=1 -> right paddle tracks ball, never misses at defaults.
